// File: rtl/multi_chan_fifo_pkg.sv
// Shared constants and helpers for the multi-channel FIFO.
// Sized defaults plus width helpers used by the top and slice.
package multi_chan_fifo_pkg;

  localparam int OVF_CNT_W  = 16;
  localparam int NUM_CH_DEF = 3;
  localparam int DATA_W_DEF = 8;
  localparam int DEPTH_DEF  = 4;

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int ch_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/chan_fifo_slice.sv
// Single-channel circular queue: storage, pointers, occupancy.
// Head is storage-derived, so a pop exposes the next word next cycle.
module chan_fifo_slice
  import multi_chan_fifo_pkg::*;
#(
  parameter  int DATA_W = DATA_W_DEF,
  parameter  int DEPTH  = DEPTH_DEF,
  localparam int CNT_W  = cnt_width(DEPTH),
  localparam int PTR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_ready_i,
  output logic              rd_valid_o,
  output logic [DATA_W-1:0] rd_data_o,
  output logic [CNT_W-1:0]  count_o,
  output logic              full_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wptr_q, wptr_d;
  logic [PTR_W-1:0]  rptr_q, rptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              wr, rd;

  assign full_o     = (cnt_q == CNT_W'(DEPTH));
  assign rd_valid_o = (cnt_q != '0);
  assign rd_data_o  = mem_q[rptr_q];
  assign count_o    = cnt_q;

  assign wr = wr_en_i && !full_o;
  assign rd = rd_valid_o && rd_ready_i;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (wr) wptr_d = wptr_q + 1'b1;
    if (rd) rptr_d = rptr_q + 1'b1;
    unique case ({wr, rd})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage is deliberately not reset; pointers make stale words invisible.
  always_ff @(posedge clk) begin
    if (wr && !rst) mem_q[wptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/multi_chan_fifo.sv
// Multi-channel FIFO top: write demux, ready mux, output packing.
// MULTI_CHAN_FIFO_OVF_CNT_EN enables the saturating rejected-write counter.
module multi_chan_fifo
  import multi_chan_fifo_pkg::*;
#(
  parameter  int NUM_CH = NUM_CH_DEF,
  parameter  int DATA_W = DATA_W_DEF,
  parameter  int DEPTH  = DEPTH_DEF,
  localparam int CH_W   = ch_width(NUM_CH),
  localparam int CNT_W  = cnt_width(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [CH_W-1:0]         in_ch,
  input  logic [DATA_W-1:0]       in_data,
  output logic                    in_ready,
  output logic [NUM_CH-1:0]       out_valid,
  input  logic [NUM_CH-1:0]       out_ready,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic [NUM_CH*CNT_W-1:0] count,
  output logic [OVF_CNT_W-1:0]    ovf_cnt
);

  logic [NUM_CH-1:0] full;
  logic [NUM_CH-1:0] wr_en;

  // Out-of-range channel indices match no slice, so ready stays low.
  always_comb begin
    in_ready = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (in_ch == CH_W'(k)) in_ready = !full[k];
    end
  end

  always_comb begin
    wr_en = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      wr_en[k] = in_valid && in_ready && (in_ch == CH_W'(k));
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    chan_fifo_slice #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
    ) u_slice (
      .clk        (clk),
      .rst        (rst),
      .wr_en_i    (wr_en[k]),
      .wr_data_i  (in_data),
      .rd_ready_i (out_ready[k]),
      .rd_valid_o (out_valid[k]),
      .rd_data_o  (out_data[k*DATA_W +: DATA_W]),
      .count_o    (count[k*CNT_W +: CNT_W]),
      .full_o     (full[k])
    );
  end

`ifdef MULTI_CHAN_FIFO_OVF_CNT_EN
  logic [OVF_CNT_W-1:0] ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q;
    if (in_valid && !in_ready && (ovf_q != '1)) ovf_d = ovf_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) ovf_q <= '0;
    else     ovf_q <= ovf_d;
  end

  assign ovf_cnt = ovf_q;
`else
  assign ovf_cnt = '0;
`endif

endmodule

// File: tb/tb_multi_chan_fifo.sv
// Randomised bench for multi_chan_fifo against a queue-based model.
// Directed scenarios first, then a random traffic phase.
module tb_multi_chan_fifo;

  localparam int NCH = 3;
  localparam int DW  = 8;
  localparam int DEP = 4;
  localparam int CW  = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic [1:0]        in_ch;
  logic [DW-1:0]     in_data;
  logic              in_ready;
  logic [NCH-1:0]    out_valid;
  logic [NCH-1:0]    out_ready;
  logic [NCH*DW-1:0] out_data;
  logic [NCH*CW-1:0] count;
  logic [15:0]       ovf_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  logic [DW-1:0] q [NCH][$];
  int            ovf_m = 0;

  multi_chan_fifo dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ch     (in_ch),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count),
    .ovf_cnt   (ovf_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs();
    int exp_ovf;
    for (int k = 0; k < NCH; k++) begin
      chk($sformatf("valid%0d", k), 32'(out_valid[k]),
          32'(q[k].size() != 0));
      chk($sformatf("count%0d", k), 32'(count[k*CW +: CW]),
          32'(q[k].size()));
      if (q[k].size() != 0)
        chk($sformatf("data%0d", k), 32'(out_data[k*DW +: DW]),
            32'(q[k][0]));
    end
`ifdef MULTI_CHAN_FIFO_OVF_CNT_EN
    exp_ovf = ovf_m;
`else
    exp_ovf = 0;
`endif
    chk("ovf", 32'(ovf_cnt), 32'(exp_ovf));
  endtask

  // Called just after a falling edge; drives one cycle, then checks.
  task automatic cycle(input bit v, input int ch, input logic [DW-1:0] d,
                       input logic [NCH-1:0] rdy, input bit r);
    bit exp_rdy;
    rst       = r;
    in_valid  = v;
    in_ch     = 2'(ch);
    in_data   = d;
    out_ready = rdy;
    #1;
    exp_rdy = (ch < NCH) && (q[ch].size() < DEP);
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    if (r) begin
      for (int k = 0; k < NCH; k++) q[k].delete();
      ovf_m = 0;
    end else begin
      for (int k = 0; k < NCH; k++)
        if (rdy[k] && q[k].size() != 0) void'(q[k].pop_front());
      if (v && exp_rdy) q[ch].push_back(d);
      if (v && !exp_rdy && ovf_m < 16'hFFFF) ovf_m++;
    end
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    rst = 1'b1; in_valid = 0; in_ch = 0; in_data = 0; out_ready = 0;
    @(negedge clk);
    cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0);

    cycle(1, 1, 8'hA5, 0, 0);
    chk("tp_valid", 32'(out_valid), 32'h2);
    cycle(0, 1, 0, 3'b010, 0);

    for (int i = 1; i <= 4; i++) cycle(1, 0, 8'(i), 0, 0);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 2, 0, 0, 0);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 3'b001, 0);

    for (int i = 0; i < 3; i++) cycle(1, 2, 8'(8'h20 + i), 0, 0);
    cycle(1, 2, 8'h23, 0, 0);
    cycle(1, 2, 8'h24, 3'b100, 0);
    chk("tp_full_cnt", 32'(count[2*CW +: CW]), 32'd3);

    cycle(1, 1, 8'h40, 0, 0);
    cycle(1, 1, 8'h41, 0, 0);
    for (int i = 0; i < 10; i++) cycle(1, 1, 8'(8'h50 + i), 3'b010, 0);
    chk("tp_sust_cnt", 32'(count[1*CW +: CW]), 32'd2);

    cycle(1, 3, 8'hEE, 0, 0);

    cycle(1, 0, 8'h61, 0, 0);
    cycle(1, 0, 8'h62, 0, 0);
    cycle(1, 0, 8'h63, 0, 1);
    chk("tp_rst_valid", 32'(out_valid), 32'h0);
    cycle(0, 0, 0, 3'b111, 0);

    for (int i = 0; i < 600; i++)
      cycle(($urandom_range(0, 3) != 0), $urandom_range(0, 3),
            8'($urandom), 3'($urandom), ($urandom_range(0, 99) == 0));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
